// File: rtl/risc_pkg.sv
// Shared definitions for the fetch slice: IF/ID bundle field positions,
// PC/instruction widths, the default bubble instruction and the fetch FSM states.
package risc_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned IFID_W  = 69;

   localparam int unsigned IFID_INPORT_MSB  = 68;
   localparam int unsigned IFID_INPORT_LSB  = 53;
   localparam int unsigned IFID_PC_MSB      = 52;
   localparam int unsigned IFID_PC_LSB      = 21;
   localparam int unsigned IFID_INSTR_MSB   = 20;
   localparam int unsigned IFID_INSTR_LSB   = 5;
   localparam int unsigned IFID_INT_BIT     = 4;
   localparam int unsigned IFID_MEMREAD_BIT = 3;
   localparam int unsigned IFID_RDST_MSB    = 2;
   localparam int unsigned IFID_RDST_LSB    = 0;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      BOOT_HI = 2'd0,
      BOOT_LO = 2'd1,
      RUN     = 2'd2
   } fetch_state_e;

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_register.sv
// 69-bit IF/ID pipeline register. nop_i inserts a bubble (beats hold_i);
// the in_port and ID/EX side fields are resampled every cycle regardless.
module if_id_register import risc_pkg::*; #(
   parameter logic [INSTR_W-1:0] NOP_VAL = risc_pkg::NOP_INSTR
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               hold_i,
   input  logic               nop_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               int_i,
   input  logic [15:0]        in_port_i,
   input  logic               memread_i,
   input  logic [2:0]         rdst_i,
   output logic [IFID_W-1:0]  out_o
);

   logic [IFID_W-1:0] ifid_q, ifid_d;

   always_comb begin
      ifid_d = ifid_q;
      if (nop_i) begin
         ifid_d[IFID_PC_MSB:IFID_PC_LSB]       = '0;
         ifid_d[IFID_INSTR_MSB:IFID_INSTR_LSB] = NOP_VAL;
         ifid_d[IFID_INT_BIT]                  = 1'b0;
      end else if (!hold_i) begin
         ifid_d[IFID_PC_MSB:IFID_PC_LSB]       = pc_i;
         ifid_d[IFID_INSTR_MSB:IFID_INSTR_LSB] = instr_i;
         ifid_d[IFID_INT_BIT]                  = int_i;
      end
      ifid_d[IFID_INPORT_MSB:IFID_INPORT_LSB] = in_port_i;
      ifid_d[IFID_MEMREAD_BIT]                = memread_i;
      ifid_d[IFID_RDST_MSB:IFID_RDST_LSB]     = rdst_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ifid_q <= '0;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign out_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: two-word boot vector load, then PC sequencing with jump,
// flush, stall and interrupt-slot insertion. Interrupts exist only with FETCH_INT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000,
   parameter logic [15:0] NOP_INSTR      = risc_pkg::NOP_INSTR
) (
   input  logic        Clk,
   input  logic        Rst,
   output logic [31:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        jmp_taken,
   input  logic [31:0] jmp_target,
   input  logic        int_req,
   input  logic [15:0] in_port,
   input  logic        idex_memread,
   input  logic [2:0]  idex_rdst,
   output logic [68:0] Out
);
   import risc_pkg::*;

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d, pc_plus1;
   logic               ifid_hold, ifid_nop, ifid_int;
   logic [PC_W-1:0]    ifid_pc;
   logic [INSTR_W-1:0] ifid_instr;

`ifdef FETCH_INT_EN
   logic int_pending_q, int_pending_d, int_slot;
`else
   logic unused_int_req;
   assign unused_int_req = int_req;
`endif

   always_comb begin
      pc_plus1   = pc_inc(pc_q);
      state_d    = state_q;
      pc_d       = pc_q;
      imem_addr  = pc_q;
      ifid_hold  = 1'b0;
      ifid_nop   = 1'b0;
      ifid_pc    = pc_plus1;
      ifid_instr = imem_data;
      ifid_int   = 1'b0;
`ifdef FETCH_INT_EN
      int_slot   = 1'b0;
`endif
      case (state_q)
         BOOT_HI: begin
            imem_addr = RESET_VEC_ADDR;
            pc_d      = {imem_data, pc_q[15:0]};
            ifid_nop  = 1'b1;
            state_d   = BOOT_LO;
         end
         BOOT_LO: begin
            imem_addr = RESET_VEC_ADDR + 32'd1;
            pc_d      = {pc_q[31:16], imem_data};
            ifid_nop  = 1'b1;
            state_d   = RUN;
         end
         RUN: begin
            if (jmp_taken) begin
               pc_d     = jmp_target;
               ifid_nop = 1'b1;
            end else if (flush) begin
               ifid_nop = 1'b1;
               if (!stall) pc_d = pc_plus1;
            end
`ifdef FETCH_INT_EN
            // Slot records the un-incremented PC so the interrupted instruction refetches
            else if (int_pending_q) begin
               int_slot   = 1'b1;
               ifid_pc    = pc_q;
               ifid_instr = NOP_INSTR;
               ifid_int   = 1'b1;
            end
`endif
            else if (stall) begin
               ifid_hold = 1'b1;
            end else begin
               pc_d = pc_plus1;
            end
         end
         default: begin
            ifid_nop = 1'b1;
            state_d  = BOOT_HI;
         end
      endcase
`ifdef FETCH_INT_EN
      int_pending_d = int_slot ? int_req : (int_pending_q | int_req);
`endif
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q       <= BOOT_HI;
         pc_q          <= '0;
`ifdef FETCH_INT_EN
         int_pending_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
`ifdef FETCH_INT_EN
         int_pending_q <= int_pending_d;
`endif
      end
   end

   if_id_register #(
      .NOP_VAL(NOP_INSTR)
   ) u_if_id (
      .clk_i    (Clk),
      .rst_ni   (Rst),
      .hold_i   (ifid_hold),
      .nop_i    (ifid_nop),
      .pc_i     (ifid_pc),
      .instr_i  (ifid_instr),
      .int_i    (ifid_int),
      .in_port_i(in_port),
      .memread_i(idex_memread),
      .rdst_i   (idex_rdst),
      .out_o    (Out)
   );

endmodule
